// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcodes, FSM state encoding and flag bit positions.
// Pure declarations; no latency and no backpressure.
package alu_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_NOT = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Bit positions inside the {Z,N,C,V} flags vector
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_exec_and16.sv
// 16-bit bitwise AND, purely combinational.
// Zero latency; no backpressure.
module And16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  assign y = a & b;

endmodule

// File: rtl/alu_exec.sv
// Single-issue ALU: 1-cycle latency for logic/add/shift ops, 17 cycles for the shift-add multiply.
// valid/ready on both sides; result is held in HOLD until out_ready, which also reopens the input.
module alu_exec #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);
  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t             state, state_nxt;
  logic               accept;
  logic               mul_done;
  logic [WIDTH-1:0]   and_y;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_err;
  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
  logic [CW-1:0]      sh;
  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    mk_flags         = '0;
    mk_flags[FLAG_Z] = (r == '0);
    mk_flags[FLAG_N] = r[WIDTH-1];
    mk_flags[FLAG_C] = c;
    mk_flags[FLAG_V] = v;
  endfunction

  And16 u_and (
    .a (a),
    .b (b),
    .y (and_y)
  );

  assign sh    = b[CW-1:0];
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  // One guard bit on each side catches the last bit shifted out; it stays 0 for a zero shift
  assign shl_w = {1'b0, a} << sh;
  assign shr_w = {a, 1'b0} >> sh;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_AND: alu_res = and_y;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OP_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign mul_done = (state == ST_MUL) && (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_MUL:  if (mul_done) state_nxt = ST_HOLD;
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rst) in_ready = 1'b0;
    accept = in_valid && in_ready;
    if (accept) state_nxt = (op == OP_MUL) ? ST_MUL : ST_HOLD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      flags  <= '0;
      err    <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        result <= alu_res;
        flags  <= mk_flags(alu_res, alu_c, alu_v);
        err    <= alu_err;
      end
    end else if (state == ST_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (mul_done) begin
        result <= acc_nxt[WIDTH-1:0];
        flags  <= mk_flags(acc_nxt[WIDTH-1:0], |acc_nxt[2*WIDTH-1:WIDTH], 1'b0);
        err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed corner cases plus random traffic scored against an arithmetic model.
module tb_alu_exec;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [3:0]  op, flags;
  logic [15:0] a, b, result;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  alu_exec #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    exp_t        e;
    int unsigned ux = x, uy = y, s;
    int          sx = $signed(x), sy = $signed(y), ss;
    int          n  = y[3:0];
    longint unsigned p;
    logic c = 1'b0, v = 1'b0;
    e.res = 16'h0;
    e.err = 1'b0;
    case (o)
      4'd0: e.res = x & y;
      4'd1: e.res = x | y;
      4'd2: e.res = x ^ y;
      4'd3: e.res = ~x;
      4'd4: begin
        s = ux + uy; e.res = s[15:0]; c = s[16];
        ss = sx + sy; v = (ss > 32767) || (ss < -32768);
      end
      4'd5: begin
        e.res = x - y; c = (ux < uy);
        ss = sx - sy; v = (ss > 32767) || (ss < -32768);
      end
      4'd6: begin e.res = x << n; c = (n == 0) ? 1'b0 : x[16-n]; end
      4'd7: begin e.res = x >> n; c = (n == 0) ? 1'b0 : x[n-1]; end
      4'd8: begin
        p = longint'(ux) * longint'(uy);
        e.res = p[15:0]; c = (p[31:16] != 0);
      end
      default: e.err = 1'b1;
    endcase
    e.flags = {(e.res == 16'h0), e.res[15], c, v};
    return e;
  endfunction

  // Scoreboard: log every accept, match every output handshake in order
  always @(negedge clk) begin
    exp_t e;
    if (rst) sb_q.delete();
    else begin
      if (out_valid && out_ready) begin
        check_val("out_has_pending", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_val("sb_result", 32'(result), 32'(e.res));
          check_val("sb_flags", 32'(flags), 32'(e.flags));
          check_val("sb_err", 32'(err), 32'(e.err));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(op, a, b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    logic got = 1'b0;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      tick();
    end
    in_valid = 1'b0;
    check_val("send_accept", 32'(got), 1);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic ir_seen, ov_seen, acc_d;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 4'h0; a = 16'h0; b = 16'h0;
    tick(); tick();
    check_val("rst_in_ready", 32'(in_ready), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_outputs", {11'h0, err, flags, result}, 0);
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", 32'(in_ready), 1);
    tick();

    send(4'd0, 16'hF0F0, 16'h3C3C);
    check_val("and_valid", 32'(out_valid), 1);
    check_val("and_result", 32'(result), 32'h3030);
    check_val("and_flags", 32'(flags), 32'h0);
    tick();

    send(4'd4, 16'h7FFF, 16'h0001);
    check_val("add_result", 32'(result), 32'h8000);
    check_val("add_flags", 32'(flags), 32'b0101);
    tick();
    send(4'd5, 16'h0001, 16'h0002);
    check_val("sub_result", 32'(result), 32'hFFFF);
    check_val("sub_flags", 32'(flags), 32'b0110);
    tick();

    send(4'd8, 16'h0100, 16'h0100);
    lat = 1; ir_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_seen = 1'b1;
      tick();
      lat++;
    end
    check_val("mul_latency", 32'(lat), 17);
    check_val("mul_in_ready_low", 32'(ir_seen), 0);
    check_val("mul_result", 32'(result), 32'h0000);
    check_val("mul_flags", 32'(flags), 32'b1010);
    tick();

    // Stall in HOLD while the next request waits upstream
    out_ready = 1'b0;
    send(4'd2, 16'h1234, 16'h00FF);
    op = 4'd1; a = 16'h00F0; b = 16'h0F00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_val("hold_valid", 32'(out_valid), 1);
      check_val("hold_result", 32'(result), 32'h12CB);
      check_val("hold_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_val("b2b_1", {15'h0, out_valid, result}, {15'h0, 1'b1, 16'h0FF0});
    op = 4'd4; a = 16'h0003; b = 16'h0004;
    tick();
    check_val("b2b_2", {15'h0, out_valid, result}, {15'h0, 1'b1, 16'h0007});
    in_valid = 1'b0;
    tick();
    check_val("b2b_idle", 32'(out_valid), 0);

    send(4'd8, 16'h0003, 16'h0005);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    #1;
    check_val("mulrst_out_valid", 32'(out_valid), 0);
    check_val("mulrst_outputs", {11'h0, err, flags, result}, 0);
    check_val("mulrst_in_ready", 32'(in_ready), 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check_val("mulrst_release_ready", 32'(in_ready), 1);
    ov_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) ov_seen = 1'b1;
      tick();
    end
    check_val("mulrst_no_output", 32'(ov_seen), 0);

    send(4'hC, 16'h1234, 16'h5678);
    check_val("illegal_err", 32'(err), 1);
    check_val("illegal_result", 32'(result), 0);
    check_val("illegal_flags", 32'(flags), 32'b1000);
    tick();

    // Random traffic; a refused request is held unchanged until taken
    acc_d = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!in_valid || acc_d) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(9, 15));
        a = rnd16();
        b = rnd16();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_d = in_valid && in_ready;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) tick();
    tick();
    check_val("drain_empty", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width; only 16 is required to be supported.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port op  input  4  opcode, from the shared package.
REQ-007 SHALL have port a  input  16  operand A.
REQ-008 SHALL have port b  input  16  operand B.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the result.
REQ-011 SHALL have port result  output  16  registered result.
REQ-012 SHALL have port flags  output  4  registered {Z,N,C,V}.
REQ-013 SHALL have port err  output  1  registered, high with a result produced by an illegal opcode.

Function
REQ-014 SHALL accept a request on a rising edge where in_valid and in_ready are both high; a, b and op SHALL be sampled at that edge.
REQ-015 SHALL implement opcodes: 0 AND, 1 OR, 2 XOR, 3 NOT a, 4 ADD, 5 SUB (a-b), 6 SHL a by b[3:0], 7 SHR logical a by b[3:0], 8 MUL (low 16 bits of a*b, unsigned).
REQ-016 SHALL treat opcodes 9-15 as illegal: result 0, flags 0 except Z=1, err=1.
REQ-017 SHALL use a three-state FSM: IDLE, MUL, HOLD.
REQ-018 IDLE: in_ready=1, out_valid=0; accepting a non-MUL op goes to HOLD with result registered at the same edge, giving 1-cycle latency; accepting MUL goes to MUL.
REQ-019 MUL: in_ready=0; shift-add over exactly 16 cycles; HOLD is entered on the 16th edge after acceptance, so out_valid rises 17 cycles after the accept edge.
REQ-020 HOLD: out_valid=1; result, flags and err SHALL stay stable until out_ready=1.
REQ-021 HOLD with out_ready=1 SHALL drive in_ready=1, so a new request is accepted on the same edge.
REQ-022 At that edge (REQ-021), the next state SHALL follow the new request: HOLD or MUL; if in_valid=0, the next state SHALL be IDLE.
REQ-023 Z SHALL be result==0 and N SHALL be result[15], for all legal ops.
REQ-024 ADD: C=carry out; V=signed overflow.
REQ-025 SUB: C=1 when a<b unsigned (borrow); V=signed overflow.
REQ-026 SHL/SHR: C=last bit shifted out, 0 when shift amount is 0; V=0.
REQ-027 MUL: C=1 when product bits [31:16] are nonzero; V=0.
REQ-028 AND/OR/XOR/NOT: C=0, V=0.
REQ-029 SHALL ignore in_valid while in MUL, or in HOLD with out_ready=0; upstream SHALL hold its request.
REQ-030 SHALL produce exactly one out_valid handshake per accepted request, in acceptance order.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE; out_valid, result, flags and err SHALL go to 0; the multiplier accumulator SHALL clear.
REQ-032 Reset during MUL or HOLD SHALL discard the operation; no out_valid for it after reset release.
REQ-033 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after release.

Structure
REQ-034 Shared package alu_pkg SHALL hold WIDTH, the opcode constants, the FSM state encoding and the flag bit indices.
REQ-035 The AND path SHALL instantiate the existing 16-bit AND sub-module And16; all other logic SHALL be in alu_exec.

Verification
REQ-036 AND a=16'hF0F0, b=16'h3C3C, out_ready=1 -> next cycle out_valid=1, result=16'h3030, Z=0, N=0, C=0, V=0.
REQ-037 ADD 16'h7FFF+16'h0001 -> result=16'h8000, N=1, V=1, C=0; SUB 16'h0001-16'h0002 -> result=16'hFFFF, C=1, N=1.
REQ-038 MUL 16'h0100*16'h0100 -> out_valid exactly 17 cycles after accept, result=16'h0000, Z=1, C=1; in_ready=0 throughout.
REQ-039 out_ready=0 for 5 cycles during HOLD -> result stable, in_ready=0; then out_ready=1 with a new in_valid -> back-to-back accept, one result per cycle.
REQ-040 Assert rst at cycle 8 of a MUL -> outputs 0 immediately, no out_valid after release; op=4'hC -> err=1, result=0, Z=1.
